// File: rtl/reset_seq.sv
// Staged reset sequencer: a power-on hold, ascending per-stage release, and a slow clock-enable tick.
// Define RSTGEN_WDT_EN to build in the watchdog that restarts the sequence while in RUN.
module reset_seq #(
   parameter int unsigned POR_CYCLES = 16,
   parameter int unsigned STAGE_GAP  = 4,
   parameter int unsigned N_STAGES   = 2,
   parameter int unsigned CE_DIV     = 6,
   parameter int unsigned WDT_CYCLES = 6000000
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                sw_req_i,
   input  logic                wdt_kick_i,
   output logic [N_STAGES-1:0] rst_out_o,
   output logic                ready_o,
   output logic                ce_out_o,
   output logic                wdt_fired_o
);

   localparam int unsigned PorW = $clog2(POR_CYCLES + 1);
   localparam int unsigned GapW = $clog2(STAGE_GAP + 1);
   localparam int unsigned IdxW = $clog2(N_STAGES + 1);
   localparam int unsigned DivW = $clog2(CE_DIV + 1);

   localparam logic [PorW-1:0] PorMax  = PorW'(POR_CYCLES);
   localparam logic [GapW-1:0] GapMax  = GapW'(STAGE_GAP);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(N_STAGES - 1);
   localparam logic [DivW-1:0] DivMax  = DivW'(CE_DIV);

   localparam logic [1:0] StHold  = 2'd0;
   localparam logic [1:0] StStage = 2'd1;
   localparam logic [1:0] StRun   = 2'd2;

   // Declaration initialisers give the post-configuration state, so the sequence runs without rst.
   logic [1:0]          state_q   = StHold;
   logic [PorW-1:0]     por_cnt_q = '0;
   logic [GapW-1:0]     gap_cnt_q = '0;
   logic [IdxW-1:0]     idx_q     = '0;
   logic [N_STAGES-1:0] rst_out_q = '1;
   logic                ready_q   = 1'b0;
   logic [DivW-1:0]     div_q     = '0;
   logic                ce_q      = 1'b0;

   logic [1:0]          state_d;
   logic [PorW-1:0]     por_cnt_d;
   logic [GapW-1:0]     gap_cnt_d;
   logic [GapW-1:0]     gap_inc;
   logic [IdxW-1:0]     idx_d;
   logic [N_STAGES-1:0] rst_out_d;
   logic                ready_d;
   logic [DivW-1:0]     div_d;
   logic [DivW-1:0]     div_inc;
   logic                ce_d;

   logic                wdt_fire;
   logic                restart;

   assign restart = rst_i | sw_req_i | wdt_fire;

   always_comb begin
      state_d   = state_q;
      por_cnt_d = por_cnt_q;
      gap_cnt_d = gap_cnt_q;
      idx_d     = idx_q;
      rst_out_d = rst_out_q;
      ready_d   = ready_q;
      gap_inc   = gap_cnt_q + 1'b1;
      case (state_q)
         StHold: begin
            rst_out_d = '1;
            ready_d   = 1'b0;
            if (por_cnt_q == PorMax) begin
               // Shifting in a zero clears the lowest still-asserted stage.
               rst_out_d = rst_out_q << 1;
               por_cnt_d = '0;
               gap_cnt_d = '0;
               idx_d     = IdxW'(1);
               if (N_STAGES == 1) begin
                  state_d = StRun;
                  ready_d = 1'b1;
               end else begin
                  state_d = StStage;
               end
            end else begin
               por_cnt_d = por_cnt_q + 1'b1;
            end
         end
         StStage: begin
            if (gap_inc == GapMax) begin
               rst_out_d = rst_out_q << 1;
               gap_cnt_d = '0;
               if (idx_q == LastIdx) begin
                  state_d = StRun;
                  ready_d = 1'b1;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               gap_cnt_d = gap_inc;
            end
         end
         StRun: begin
            rst_out_d = '0;
            ready_d   = 1'b1;
         end
         default: begin
            state_d   = StHold;
            por_cnt_d = '0;
            gap_cnt_d = '0;
            idx_d     = '0;
            rst_out_d = '1;
            ready_d   = 1'b0;
         end
      endcase
   end

   // Divider idles while stage 0 is still in reset.
   always_comb begin
      div_d   = div_q;
      ce_d    = 1'b0;
      div_inc = div_q + 1'b1;
      if (rst_out_q[0]) begin
         div_d = '0;
      end else if (div_inc == DivMax) begin
         div_d = '0;
         ce_d  = 1'b1;
      end else begin
         div_d = div_inc;
      end
   end

   always_ff @(posedge clk_i) begin
      if (restart) begin
         state_q   <= StHold;
         por_cnt_q <= '0;
         gap_cnt_q <= '0;
         idx_q     <= '0;
         rst_out_q <= '1;
         ready_q   <= 1'b0;
         div_q     <= '0;
         ce_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         por_cnt_q <= por_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         idx_q     <= idx_d;
         rst_out_q <= rst_out_d;
         ready_q   <= ready_d;
         div_q     <= div_d;
         ce_q      <= ce_d;
      end
   end

`ifdef RSTGEN_WDT_EN
   localparam int unsigned WdtW = $clog2(WDT_CYCLES + 1);
   localparam logic [WdtW-1:0] WdtMax = WdtW'(WDT_CYCLES);

   logic [WdtW-1:0] wdt_cnt_q = '0;
   logic [WdtW-1:0] wdt_cnt_d;
   logic [WdtW-1:0] wdt_inc;
   logic            fired_q   = 1'b0;
   logic            fired_d;

   // A kick on the terminal cycle wins over the timeout.
   always_comb begin
      wdt_cnt_d = '0;
      wdt_fire  = 1'b0;
      wdt_inc   = wdt_cnt_q + 1'b1;
      if (state_q == StRun) begin
         if (wdt_kick_i) begin
            wdt_cnt_d = '0;
         end else if (wdt_inc == WdtMax) begin
            wdt_fire = 1'b1;
         end else begin
            wdt_cnt_d = wdt_inc;
         end
      end
   end

   always_comb begin
      fired_d = fired_q;
      if (rst_i) begin
         fired_d = 1'b0;
      end else if (wdt_fire) begin
         fired_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (restart) begin
         wdt_cnt_q <= '0;
      end else begin
         wdt_cnt_q <= wdt_cnt_d;
      end
      fired_q <= fired_d;
   end

   assign wdt_fired_o = fired_q;
`else
   logic unused_wdt_kick;

   assign unused_wdt_kick = wdt_kick_i;
   assign wdt_fire        = 1'b0;
   assign wdt_fired_o     = 1'b0;
`endif

   assign rst_out_o = rst_out_q;
   assign ready_o   = ready_q;
   assign ce_out_o  = ce_q;

endmodule
